// File: rtl/jtframe_info_scan.sv
// Per-frame status-port scanner: walks ADDR_LIST once per LVBL falling edge,
// captures the returned bytes into a shadow buffer, commits them atomically
// into a display buffer and serves that buffer as ASCII hex characters.
module jtframe_info_scan #(
    parameter int unsigned               ENTRIES   = 8,
    parameter logic [8*ENTRIES-1:0]      ADDR_LIST = {8'h80, 8'h41, 8'h40, 8'h03,
                                                      8'h02, 8'h01, 8'h00, 8'h00},
    parameter int unsigned               LAT       = 2
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       LVBL,
    input  logic       enable,
    output logic [7:0] st_addr,
    input  logic [7:0] st_dout,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int unsigned IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned WW = 3;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        WAIT,
        CAPT,
        COMMIT
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [WW-1:0]   wcnt, wcnt_nx;
    logic [7:0]      addr_nx;
    logic            cap, commit;
    logic            lvbl_l;
    logic            trig;
    logic [7:0]      shadow [ENTRIES];
    logic [7:0]      disp   [ENTRIES];
    logic [7:0]      sel_byte;
    logic [3:0]      nib;
    logic [7:0]      rd_char_nx;

    assign trig = ~LVBL & lvbl_l & enable;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and scan-control decode
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wcnt_nx  = wcnt;
        addr_nx  = st_addr;
        cap      = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    idx_nx   = '0;
                    state_nx = SET;
                end
            end
            SET: begin
                addr_nx  = ADDR_LIST[{idx, 3'b000} +: 8];
                wcnt_nx  = WW'(LAT - 1);
                state_nx = WAIT;
            end
            WAIT: begin
                if (wcnt == '0) state_nx = CAPT;
                else            wcnt_nx  = wcnt - WW'(1);
            end
            CAPT: begin
                cap = 1'b1;
                if (idx == IW'(ENTRIES - 1)) begin
                    state_nx = COMMIT;
                end else begin
                    idx_nx   = idx + IW'(1);
                    state_nx = SET;
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Hex-character lookup of the committed buffer
    always_comb begin
        rd_char_nx = 8'h20;
        sel_byte   = '0;
        nib        = '0;
        if ({1'b0, rd_addr} < 6'(2 * ENTRIES)) begin
            sel_byte   = disp[rd_addr[IW:1]];
            nib        = rd_addr[0] ? sel_byte[3:0] : sel_byte[7:4];
            rd_char_nx = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end
    end

    // Datapath, status flags and buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvbl_l  <= 1'b0;
            idx     <= '0;
            wcnt    <= '0;
            st_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            rd_char <= 8'h20;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                shadow[i] <= '0;
                disp[i]   <= '0;
            end
        end else begin
            lvbl_l  <= LVBL;
            idx     <= idx_nx;
            wcnt    <= wcnt_nx;
            st_addr <= addr_nx;
            busy    <= (state_nx != IDLE);
            done    <= (state_nx == COMMIT);
            rd_char <= rd_char_nx;
            if (trig && (state != IDLE)) overrun <= 1'b1;
            if (cap) shadow[idx] <= st_dout;
            if (commit) begin
                for (int i = 0; i < int'(ENTRIES); i++) disp[i] <= shadow[i];
            end
        end
    end

endmodule
